// File: rtl/ddr3_wr_tx.sv
// DDR3 write datapath transmitter: sequences DQS preamble, burst data and
// postamble for one byte group, with seamless back-to-back burst chaining.
module ddr3_wr_tx #(
  parameter int unsigned DQ_W = 8,
  parameter int unsigned BL   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_start,
  input  logic [2*DQ_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DQ_W-1:0]   dq_o_rise,
  output logic [DQ_W-1:0]   dq_o_fall,
  output logic              dq_t,
  output logic              dqs_o_rise,
  output logic              dqs_o_fall,
  output logic              dqs_t,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int unsigned BEATS = BL / 2;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BURST = 2'd2,
    POST  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_beat;

  logic [DQ_W-1:0]   dq_rise_d, dq_fall_d;
  logic              dq_t_d, dqs_t_d, dqs_rise_d, dqs_fall_d;
  logic              busy_d, done_d, underrun_d;

  assign last_beat = (state_q == BURST) && (cnt_q == CNT_W'(BEATS - 1));

  // Next-state, beat counter, input handshake and next values of pad outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ready   = 1'b0;
    dq_rise_d  = '0;
    dq_fall_d  = '0;
    dq_t_d     = 1'b1;
    dqs_t_d    = 1'b1;
    dqs_rise_d = 1'b0;
    dqs_fall_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    underrun_d = underrun;

    case (state_q)
      IDLE: begin
        if (wr_start) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        wr_ready = 1'b1;
        state_d  = BURST;
        cnt_d    = '0;
      end
      BURST: begin
        if (!last_beat) begin
          wr_ready = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else if (wr_start) begin
          wr_ready = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d  = POST;
          cnt_d    = '0;
        end
      end
      POST: begin
        state_d = wr_start ? PRE : IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A granted slot with no valid word sends zeros and flags the underrun
    if (wr_ready) begin
      if (wr_valid) begin
        dq_rise_d = wr_data[DQ_W-1:0];
        dq_fall_d = wr_data[2*DQ_W-1:DQ_W];
      end else begin
        underrun_d = 1'b1;
      end
    end

    // Pad controls follow the state being entered so they change only on edges
    dq_t_d     = (state_d != BURST);
    dqs_t_d    = (state_d == IDLE);
    dqs_rise_d = (state_d == BURST);
    busy_d     = (state_d != IDLE);
    done_d     = last_beat;
  end

  // State and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dq_o_rise  <= '0;
      dq_o_fall  <= '0;
      dq_t       <= 1'b1;
      dqs_t      <= 1'b1;
      dqs_o_rise <= 1'b0;
      dqs_o_fall <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dq_o_rise  <= dq_rise_d;
      dq_o_fall  <= dq_fall_d;
      dq_t       <= dq_t_d;
      dqs_t      <= dqs_t_d;
      dqs_o_rise <= dqs_rise_d;
      dqs_o_fall <= dqs_fall_d;
      busy       <= busy_d;
      done       <= done_d;
      underrun   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ddr3_wr_tx.sv
// Directed bench for ddr3_wr_tx: per-cycle control expectations plus a
// scoreboard queue of expected DQ words checked by a forked monitor.
module tb_ddr3_wr_tx;

  localparam int unsigned DQ_W = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_start;
  logic [2*DQ_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DQ_W-1:0]   dq_o_rise, dq_o_fall;
  logic              dq_t, dqs_o_rise, dqs_o_fall, dqs_t;
  logic              busy, done, underrun;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  ddr3_wr_tx #(.DQ_W(DQ_W), .BL(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_start   (wr_start),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .dq_o_rise  (dq_o_rise),
    .dq_o_fall  (dq_o_fall),
    .dq_t       (dq_t),
    .dqs_o_rise (dqs_o_rise),
    .dqs_o_fall (dqs_o_fall),
    .dqs_t      (dqs_t),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bits: {dq_t, dqs_t, done, busy, wr_ready, underrun}
  task automatic check_ctl(input string name, input logic [5:0] e);
    logic [7:0] act, req;
    act = {dq_t, dqs_t, done, busy, wr_ready, underrun, dqs_o_rise, dqs_o_fall};
    req = {e, ~e[5], 1'b0};
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got dq_t,dqs_t,done,busy,rdy,und,dqs_r,dqs_f=%b required %b",
               name, act, req);
    end
  endtask

  task automatic cyc(input string name, input logic st, input logic vl,
                     input logic [15:0] d, input logic [5:0] e);
    @(posedge clk);
    #1;
    wr_start = st;
    wr_valid = vl;
    wr_data  = d;
    @(negedge clk);
    check_ctl(name, e);
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  // Standard burst front half: start in c0, words in c1..c4, cnt=3 in c5
  task automatic burst4(input string t, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic st5,
                        input logic [15:0] d5, input logic [5:0] e5);
    cyc({t, "_c0"}, 1'b1, 1'b0, 16'h0, 6'b110000);
    cyc({t, "_c1"}, 1'b0, 1'b1, a,     6'b100110);
    cyc({t, "_c2"}, 1'b0, 1'b1, b,     6'b000110);
    cyc({t, "_c3"}, 1'b0, 1'b1, c,     6'b000110);
    cyc({t, "_c4"}, 1'b0, 1'b1, d,     6'b000110);
    cyc({t, "_c5"}, st5,  st5,  d5,    e5);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;

    // Scoreboard monitor: every driven beat must match the next queued word
    fork
      forever begin
        logic [15:0] w;
        @(negedge clk);
        if (rst_n && !dq_t) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL dq_beat: got %h required none (queue empty)", {dq_o_fall, dq_o_rise});
          end else begin
            w = exp_q.pop_front();
            if ({dq_o_fall, dq_o_rise} !== w) begin
              bad++;
              $display("FAIL dq_beat: got %h required %h", {dq_o_fall, dq_o_rise}, w);
            end
          end
        end
      end
    join_none

    #12;
    total++;
    if ({dq_o_rise, dq_o_fall, dq_t, dqs_t, busy, done, underrun} !== {16'h0, 5'b11000}) begin
      bad++;
      $display("FAIL reset_state: got %h required %h",
               {dq_o_rise, dq_o_fall, dq_t, dqs_t, busy, done, underrun}, {16'h0, 5'b11000});
    end
    #4 rst_n = 1'b1;

    // Single burst
    exp_q.push_back(16'hA1A0); exp_q.push_back(16'hB1B0);
    exp_q.push_back(16'hC1C0); exp_q.push_back(16'hD1D0);
    burst4("single", 16'hA1A0, 16'hB1B0, 16'hC1C0, 16'hD1D0, 1'b0, 16'h0, 6'b000100);
    cyc("single_post", 1'b0, 1'b0, 16'h0, 6'b101100);
    cyc("single_idle", 1'b0, 1'b0, 16'h0, 6'b110000);

    // Back-to-back seamless bursts
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0302);
    exp_q.push_back(16'h0504); exp_q.push_back(16'h0706);
    exp_q.push_back(16'hE1E0); exp_q.push_back(16'hF1F0);
    exp_q.push_back(16'h9190); exp_q.push_back(16'h8180);
    burst4("b2b", 16'h0100, 16'h0302, 16'h0504, 16'h0706, 1'b1, 16'hE1E0, 6'b000110);
    cyc("b2b_c6",  1'b0, 1'b1, 16'hF1F0, 6'b001110);
    cyc("b2b_c7",  1'b0, 1'b1, 16'h9190, 6'b000110);
    cyc("b2b_c8",  1'b0, 1'b1, 16'h8180, 6'b000110);
    cyc("b2b_c9",  1'b0, 1'b0, 16'h0,    6'b000100);
    cyc("b2b_c10", 1'b0, 1'b0, 16'h0,    6'b101100);
    cyc("b2b_c11", 1'b0, 1'b0, 16'h0,    6'b110000);

    // Ignored starts in PRE and in BURST cnt=1
    exp_q.push_back(16'h1110); exp_q.push_back(16'h2120);
    exp_q.push_back(16'h3130); exp_q.push_back(16'h4140);
    cyc("ign_c0", 1'b1, 1'b0, 16'h0,    6'b110000);
    cyc("ign_c1", 1'b1, 1'b1, 16'h1110, 6'b100110);
    cyc("ign_c2", 1'b0, 1'b1, 16'h2120, 6'b000110);
    cyc("ign_c3", 1'b1, 1'b1, 16'h3130, 6'b000110);
    cyc("ign_c4", 1'b0, 1'b1, 16'h4140, 6'b000110);
    cyc("ign_c5", 1'b0, 1'b0, 16'h0,    6'b000100);
    cyc("ign_c6", 1'b0, 1'b0, 16'h0,    6'b101100);
    cyc("ign_c7", 1'b0, 1'b0, 16'h0,    6'b110000);
    cyc("ign_c8", 1'b0, 1'b0, 16'h0,    6'b110000);

    // Restart from POST: dqs_t held low across POST->PRE
    exp_q.push_back(16'h5150); exp_q.push_back(16'h6160);
    exp_q.push_back(16'h7170); exp_q.push_back(16'h8180);
    exp_q.push_back(16'hCAFE); exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    burst4("post", 16'h5150, 16'h6160, 16'h7170, 16'h8180, 1'b0, 16'h0, 6'b000100);
    cyc("post_c6",  1'b1, 1'b0, 16'h0,    6'b101100);
    cyc("post_c7",  1'b0, 1'b1, 16'hCAFE, 6'b100110);
    cyc("post_c8",  1'b0, 1'b1, 16'hBEEF, 6'b000110);
    cyc("post_c9",  1'b0, 1'b1, 16'h1234, 6'b000110);
    cyc("post_c10", 1'b0, 1'b1, 16'h5678, 6'b000110);
    cyc("post_c11", 1'b0, 1'b0, 16'h0,    6'b000100);
    cyc("post_c12", 1'b0, 1'b0, 16'h0,    6'b101100);
    cyc("post_c13", 1'b0, 1'b0, 16'h0,    6'b110000);

    // Underrun on the third word, sticky until reset
    exp_q.push_back(16'hAA55); exp_q.push_back(16'h55AA);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0F0F);
    cyc("und_c0", 1'b1, 1'b0, 16'h0,    6'b110000);
    cyc("und_c1", 1'b0, 1'b1, 16'hAA55, 6'b100110);
    cyc("und_c2", 1'b0, 1'b1, 16'h55AA, 6'b000110);
    cyc("und_c3", 1'b0, 1'b0, 16'hFFFF, 6'b000110);
    cyc("und_c4", 1'b0, 1'b1, 16'h0F0F, 6'b000111);
    cyc("und_c5", 1'b0, 1'b0, 16'h0,    6'b000101);
    cyc("und_c6", 1'b0, 1'b0, 16'h0,    6'b101101);
    cyc("und_c7", 1'b0, 1'b0, 16'h0,    6'b110001);
    cyc("und_c8", 1'b0, 1'b0, 16'h0,    6'b110001);
    idle_in();
    rst_n = 1'b0;
    #1 check_ctl("und_cleared", 6'b110000);
    #3 rst_n = 1'b1;

    // Reset mid-burst (cnt=1), then a clean burst
    exp_q.push_back(16'hDEAD);
    cyc("rst_c0", 1'b1, 1'b0, 16'h0,    6'b110000);
    cyc("rst_c1", 1'b0, 1'b1, 16'hDEAD, 6'b100110);
    cyc("rst_c2", 1'b0, 1'b1, 16'hBEEF, 6'b000110);
    idle_in();
    rst_n = 1'b0;
    #1 check_ctl("rst_abort", 6'b110000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc("rst_quiet", 1'b0, 1'b0, 16'h0, 6'b110000);
    exp_q.push_back(16'h0A0B); exp_q.push_back(16'h0C0D);
    exp_q.push_back(16'h0E0F); exp_q.push_back(16'h1011);
    burst4("clean", 16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 1'b0, 16'h0, 6'b000100);
    cyc("clean_post", 1'b0, 1'b0, 16'h0, 6'b101100);
    cyc("clean_idle", 1'b0, 1'b0, 16'h0, 6'b110000);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d words left required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
